fifo_uart_tx: RTL and testbench

- Read-side consumer for the team's synchronous FIFO: pops one word whenever the FIFO is non-empty and transmission is enabled.
- Sends each popped word LSB-first as an asynchronous serial frame: start bit, DATA_WIDTH data bits, optional parity bit, 1 or 2 stop bits.
- Sits between the FIFO read port (rd_en / rd_data / empty) and the chip-level serial TX pin.

---
 rtl/fifo_uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Read-side consumer for a synchronous FIFO. Whenever transmission is enabled
// and the FIFO holds a word, one word is popped and sent LSB-first as an
// asynchronous serial frame: start bit, DATA_WIDTH data bits, optional parity
// bit, then STOP_BITS stop bits. Frames run back-to-back while words remain.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   tx_en        in   allows new words to be fetched (current frame always ends)
//   fifo_empty   in   FIFO empty flag
//   fifo_rd_en   out  FIFO read strobe, registered single-cycle pulse
//   fifo_rd_data in   FIFO read data, valid the cycle after fifo_rd_en
//   tx           out  serial line, registered, idles high
//   busy         out  high in every state except IDLE
//   tx_done      out  one-cycle pulse in the last cycle of the last stop bit
//   state_dbg    out  current FSM state encoding, for observation only
//
// FIFO handshake: a pop is requested only when fifo_empty was sampled low on
// the deciding edge; fifo_rd_en is then high for exactly one cycle (FETCH),
// and fifo_rd_data is captured on the following edge (end of LOAD). There is
// never more than one pop per frame, and fifo_empty is ignored between the
// pop and the end of the last stop bit.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 7,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done,
    output logic [2:0]            state_dbg
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0]         bit_timer_q;
    logic [CW-1:0]         bit_cnt_q;
    logic                  stop_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;

    logic bit_end;
    logic data_last;
    logic stop_last;
    logic can_fetch;
    logic tx_d;

    assign bit_end   = (bit_timer_q == BIT_LAST);
    assign data_last = (bit_cnt_q == DATA_LAST);
    assign stop_last = (stop_cnt_q == STOP_LAST);
    assign can_fetch = tx_en && !fifo_empty;
    assign state_dbg = state_q;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (can_fetch) state_d = FETCH;
            FETCH:  state_d = LOAD;
            LOAD:   state_d = START;
            START:  if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end && data_last) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: begin
                // Going straight to FETCH keeps frames gap-free apart from
                // the two FETCH/LOAD cycles.
                if (bit_end && stop_last) begin
                    state_d = can_fetch ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic. tx is registered from the next-state view so the pin
    // never sees decode glitches; the shift/parity values it uses are the
    // ones that will be held after the coming edge.
    // ---------------------------------------------------------------------
    always_comb begin
        shift_d  = shift_q;
        parity_d = parity_q;
        if (state_q == LOAD) begin
            shift_d  = fifo_rd_data;
            parity_d = (^fifo_rd_data) ^ ODD_BIT;
        end else if (state_q == DATA && bit_end) begin
            shift_d = shift_q >> 1;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase

        busy    = (state_q != IDLE);
        tx_done = (state_q == STOP) && bit_end && stop_last;
    end

    // ---------------------------------------------------------------------
    // Datapath and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx          <= 1'b1;
            fifo_rd_en  <= 1'b0;
            bit_timer_q <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
        end else begin
            tx         <= tx_d;
            fifo_rd_en <= (state_d == FETCH);
            shift_q    <= shift_d;
            parity_q   <= parity_d;

            // Bit timer runs only while a bit is on the line and restarts
            // at every bit boundary.
            if (state_q == IDLE || state_q == FETCH || state_q == LOAD || bit_end) begin
                bit_timer_q <= '0;
            end else begin
                bit_timer_q <= bit_timer_q + TW'(1);
            end

            if (state_q != DATA) begin
                bit_cnt_q <= '0;
            end else if (bit_end) begin
                bit_cnt_q <= bit_cnt_q + CW'(1);
            end

            if (state_q != STOP) begin
                stop_cnt_q <= 1'b0;
            end else if (bit_end) begin
                stop_cnt_q <= ~stop_cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int DW  = 7;
  localparam int CPB = 4;

  logic clk;
  logic rst_n;

  // Instance A: even parity, 1 stop bit
  logic          tx_en_a, empty_a, rd_en_a, tx_a, busy_a, done_a;
  logic [DW-1:0] rd_data_a;
  logic [2:0]    state_a;
  // Instance B: odd parity, 2 stop bits
  logic          tx_en_b, empty_b, rd_en_b, tx_b, busy_b, done_b;
  logic [DW-1:0] rd_data_b;
  logic [2:0]    state_b;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                 .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en_a), .fifo_empty(empty_a),
    .fifo_rd_en(rd_en_a), .fifo_rd_data(rd_data_a), .tx(tx_a),
    .busy(busy_a), .tx_done(done_a), .state_dbg(state_a)
  );

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                 .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en_b), .fifo_empty(empty_b),
    .fifo_rd_en(rd_en_b), .fifo_rd_data(rd_data_b), .tx(tx_b),
    .busy(busy_b), .tx_done(done_b), .state_dbg(state_b)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FIFO models ----------------
  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];
  logic [4:0]    wp_a, rp_a, wp_b, rp_b;
  int            rd_cnt_a, rd_cnt_b, pop_empty, multi_pulse;
  logic          rd_prev_a, rd_prev_b;

  assign empty_a = (wp_a == rp_a);
  assign empty_b = (wp_b == rp_b);

  initial begin
    rp_a = '0; rp_b = '0; rd_data_a = '0; rd_data_b = '0;
    rd_cnt_a = 0; rd_cnt_b = 0; pop_empty = 0; multi_pulse = 0;
    rd_prev_a = 1'b0; rd_prev_b = 1'b0;
  end

  always @(posedge clk) begin
    rd_prev_a <= rd_en_a;
    rd_prev_b <= rd_en_b;
    if (rd_en_a && rd_prev_a) multi_pulse <= multi_pulse + 1;
    if (rd_en_b && rd_prev_b) multi_pulse <= multi_pulse + 1;
    if (rd_en_a) begin
      rd_cnt_a <= rd_cnt_a + 1;
      if (wp_a == rp_a) pop_empty <= pop_empty + 1;
      else begin
        rd_data_a <= mem_a[rp_a[3:0]];
        rp_a      <= rp_a + 5'd1;
      end
    end
    if (rd_en_b) begin
      rd_cnt_b <= rd_cnt_b + 1;
      if (wp_b == rp_b) pop_empty <= pop_empty + 1;
      else begin
        rd_data_b <= mem_b[rp_b[3:0]];
        rp_b      <= rp_b + 5'd1;
      end
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_a(input logic [DW-1:0] w);
    mem_a[wp_a[3:0]] = w;
    wp_a = wp_a + 5'd1;
  endtask

  task automatic push_b(input logic [DW-1:0] w);
    mem_b[wp_b[3:0]] = w;
    wp_b = wp_b + 5'd1;
  endtask

  // Waits (bounded) for tx to fall, returning negedges waited and the first
  // negedge index at which fifo_rd_en was seen high (-1 if never).
  task automatic wait_fall(input int inst, output int fall_k, output int rd_k);
    int k;
    k = 0;
    rd_k = -1;
    while (((inst == 0) ? tx_a : tx_b) !== 1'b0 && k < 60) begin
      if (rd_k < 0 && ((inst == 0) ? rd_en_a : rd_en_b) === 1'b1) rd_k = k;
      @(negedge clk);
      k++;
    end
    fall_k = k;
    if (k >= 60) chk("tx_fall_timeout", k, 0);
  endtask

  // Entered on the first cycle of the start bit. bits[i] is serial bit i
  // (bit 0 = start). Optionally drops tx_en at the start of bit drop_bit.
  task automatic check_frame(input int inst, input logic [15:0] bits, input int nbits,
                             input int drop_bit, input string tag);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < CPB; c++) begin
        if (i == drop_bit && c == 0) begin
          if (inst == 0) tx_en_a = 1'b0;
          else           tx_en_b = 1'b0;
        end
        chk({tag, "_tx"}, int'((inst == 0) ? tx_a : tx_b), int'(bits[i]));
        chk({tag, "_done"}, int'((inst == 0) ? done_a : done_b),
            (i == nbits - 1 && c == CPB - 1) ? 1 : 0);
        chk({tag, "_busy"}, int'((inst == 0) ? busy_a : busy_b), 1);
        @(negedge clk);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  int fk, rk;

  initial begin
    n_cmp = 0; n_bad = 0;
    wp_a = '0; wp_b = '0;
    rst_n = 1'b0; tx_en_a = 1'b1; tx_en_b = 1'b0;
    push_a(7'h55);

    // Reset held 5 cycles with FIFO A non-empty and enabled
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx", int'(tx_a), 1);
      chk("rst_rd_en", int'(rd_en_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_done", int'(done_a), 0);
      chk("rst_tx_b", int'(tx_b), 1);
    end

    // Single frame 7'h55, even parity, 1 stop
    rst_n = 1'b1;
    wait_fall(0, fk, rk);
    chk("single_latency", fk, 3);
    chk("single_rd_at", rk, 1);
    check_frame(0, 16'(10'b1010101010), 10, -1, "single");
    chk("single_busy_end", int'(busy_a), 0);
    chk("single_rd_cnt", rd_cnt_a, 1);

    // Odd parity, 2 stop bits, 7'h03 -> 44-cycle frame
    push_b(7'h03);
    tx_en_b = 1'b1;
    wait_fall(1, fk, rk);
    chk("odd_latency", fk, 3);
    check_frame(1, 16'(11'b11100000110), 11, -1, "odd2stop");
    chk("odd_busy_end", int'(busy_b), 0);
    chk("odd_rd_cnt", rd_cnt_b, 1);

    // Back-to-back: 7'h01, 7'h7F, 7'h00
    tx_en_a = 1'b0;
    push_a(7'h01); push_a(7'h7F); push_a(7'h00);
    tx_en_a = 1'b1;
    wait_fall(0, fk, rk);
    chk("b2b0_latency", fk, 3);
    check_frame(0, 16'(10'b1100000010), 10, -1, "b2b0");
    chk("b2b_rd_after_done1", int'(rd_en_a), 1);
    wait_fall(0, fk, rk);
    chk("b2b1_gap_tail", fk, 2);
    check_frame(0, 16'(10'b1111111110), 10, -1, "b2b1");
    chk("b2b_rd_after_done2", int'(rd_en_a), 1);
    wait_fall(0, fk, rk);
    chk("b2b2_gap_tail", fk, 2);
    check_frame(0, 16'(10'b1000000000), 10, -1, "b2b2");
    chk("b2b_idle_busy", int'(busy_a), 0);
    chk("b2b_idle_rd", int'(rd_en_a), 0);
    chk("b2b_rd_cnt", rd_cnt_a, 4);

    // tx_en dropped during data bits of frame 1, two words queued
    tx_en_a = 1'b0;
    push_a(7'h2A); push_a(7'h15);
    tx_en_a = 1'b1;
    wait_fall(0, fk, rk);
    chk("drop_latency", fk, 3);
    check_frame(0, 16'(10'b1101010100), 10, 3, "drop_f1");
    for (int i = 0; i < 5; i++) begin
      chk("drop_hold_busy", int'(busy_a), 0);
      chk("drop_hold_rd", int'(rd_en_a), 0);
      chk("drop_hold_tx", int'(tx_a), 1);
      @(negedge clk);
    end
    chk("drop_rd_cnt", rd_cnt_a, 5);
    tx_en_a = 1'b1;
    wait_fall(0, fk, rk);
    chk("reraise_latency", fk, 3);
    check_frame(0, 16'(10'b1100101010), 10, -1, "drop_f2");
    chk("drop_rd_cnt2", rd_cnt_a, 6);

    // Reset during DATA: 7'h11 is discarded, 7'h22 is sent next
    tx_en_a = 1'b0;
    push_a(7'h11); push_a(7'h22);
    tx_en_a = 1'b1;
    wait_fall(0, fk, rk);
    chk("rstmid_latency", fk, 3);
    repeat (6) @(negedge clk);
    chk("rstmid_in_data", int'(state_a), 4);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx_async", int'(tx_a), 1);
    chk("rstmid_busy", int'(busy_a), 0);
    chk("rstmid_state", int'(state_a), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fall(0, fk, rk);
    chk("rstmid_relatency", fk, 3);
    check_frame(0, 16'(10'b1001000100), 10, -1, "rstmid_next");
    chk("rstmid_busy_end", int'(busy_a), 0);
    chk("rstmid_rd_cnt", rd_cnt_a, 8);

    // Global pop discipline
    repeat (3) @(negedge clk);
    chk("pop_empty", pop_empty, 0);
    chk("multi_pulse", multi_pulse, 0);
    chk("b_rd_cnt_final", rd_cnt_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
